sync_updown_counter: RTL and testbench

//  Parametrised synchronous up/down counter. Successor to the 4-bit ripple down-counter:
//  - all bits update on the single clk edge, so there is no ripple skew;
//  - adds selectable modulus, direction, parallel load, prescaler, wrap/saturate mode and a

---
 rtl/sync_updown_counter.sv | 86 ++++++++
 tb/tb_sync_updown_counter.sv | 134 +++++++++++++
 2 files changed

// File: rtl/sync_updown_counter.sv
// rtl/sync_updown_counter.sv - parametrised synchronous up/down counter
// Modulus, direction, parallel load, prescaler, wrap/saturate and terminal-count pulse.
module sync_updown_counter #(
  parameter int WIDTH    = 4,
  parameter int MODULO   = 16,
  parameter int SATURATE = 0,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             at_zero,
  output logic             at_max
);

  if (MODULO < 2 || MODULO > 2**WIDTH || PRESCALE < 1) begin : g_bad_params
    $error("sync_updown_counter: illegal MODULO/PRESCALE for WIDTH");
  end

  // Compares are done one bit wider so MODULO == 2**WIDTH still fits.
  localparam logic [WIDTH:0]   MAXV = (WIDTH+1)'(MODULO - 1);
  localparam logic [WIDTH-1:0] MAXC = MAXV[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH:0]   cnt_ext;
  logic [WIDTH:0]   ld_ext;
  logic [WIDTH-1:0] nxt;
  logic             step;
  logic             at_bound;

  assign cnt_ext  = {1'b0, count};
  assign ld_ext   = {1'b0, load_val};
  assign at_zero  = (count == '0);
  assign at_max   = (cnt_ext == MAXV);
  assign at_bound = up ? at_max : at_zero;

  // Off the boundary the step cannot overflow, so WIDTH bits suffice here.
  always_comb begin
    nxt = count;
    if (at_bound) begin
      if (SATURATE == 0) nxt = up ? '0 : MAXC;
    end else begin
      nxt = up ? count + ONE : count - ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      tc    <= 1'b0;
    end else if (load) begin
      count <= (ld_ext > MAXV) ? MAXC : load_val;
      tc    <= 1'b0;
    end else if (step) begin
      count <= nxt;
      tc    <= at_bound;
    end else begin
      tc    <= 1'b0;
    end
  end

  if (PRESCALE > 1) begin : g_presc
    localparam int            PW    = $clog2(PRESCALE);
    localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);
    logic [PW-1:0] presc;

    assign step = en && (presc == PLAST);

    // A gap in en holds the phase; only rst and load restart the period.
    always_ff @(posedge clk) begin
      if (rst || load) begin
        presc <= '0;
      end else if (en) begin
        presc <= (presc == PLAST) ? '0 : presc + PW'(1);
      end
    end
  end else begin : g_nopresc
    assign step = en;
  end

endmodule

// File: tb/tb_sync_updown_counter.sv
// tb/tb_sync_updown_counter.sv - scoreboard bench for sync_updown_counter
// dut0: MODULO=10 wrap; dut1: MODULO=10 saturate; dut2: MODULO=10 wrap, PRESCALE=3.
module tb_sync_updown_counter;

  logic       clk = 1'b0;
  logic       rst [3];
  logic       en  [3];
  logic       up  [3];
  logic       ld  [3];
  logic [3:0] lv  [3];
  logic [3:0] cnt [3];
  logic       tcs [3];
  logic       az  [3];
  logic       am  [3];

  typedef struct {
    int         d;
    string      nm;
    logic [3:0] c;
    logic       t;
    logic       z;
    logic       m;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  sync_updown_counter #(.WIDTH(4), .MODULO(10), .SATURATE(0), .PRESCALE(1)) dut0 (
    .clk(clk), .rst(rst[0]), .en(en[0]), .up(up[0]), .load(ld[0]), .load_val(lv[0]),
    .count(cnt[0]), .tc(tcs[0]), .at_zero(az[0]), .at_max(am[0]));

  sync_updown_counter #(.WIDTH(4), .MODULO(10), .SATURATE(1), .PRESCALE(1)) dut1 (
    .clk(clk), .rst(rst[1]), .en(en[1]), .up(up[1]), .load(ld[1]), .load_val(lv[1]),
    .count(cnt[1]), .tc(tcs[1]), .at_zero(az[1]), .at_max(am[1]));

  sync_updown_counter #(.WIDTH(4), .MODULO(10), .SATURATE(0), .PRESCALE(3)) dut2 (
    .clk(clk), .rst(rst[2]), .en(en[2]), .up(up[2]), .load(ld[2]), .load_val(lv[2]),
    .count(cnt[2]), .tc(tcs[2]), .at_zero(az[2]), .at_max(am[2]));

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_checks++;
      if (cnt[e.d] !== e.c || tcs[e.d] !== e.t || az[e.d] !== e.z || am[e.d] !== e.m) begin
        n_fail++;
        $display("FAIL %s dut%0d: got count=%0d tc=%b at_zero=%b at_max=%b, expected count=%0d tc=%b at_zero=%b at_max=%b",
                 e.nm, e.d, cnt[e.d], tcs[e.d], az[e.d], am[e.d], e.c, e.t, e.z, e.m);
      end
    end
  end

  function automatic exp_t mk(input int d, input logic [3:0] c, input logic t, input string nm);
    exp_t e;
    e.d  = d;
    e.nm = nm;
    e.c  = c;
    e.t  = t;
    e.z  = (c == 4'd0);
    e.m  = (c == 4'd9);
    return e;
  endfunction

  task automatic idle_all();
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b0; en[k] = 1'b0; up[k] = 1'b0; ld[k] = 1'b0; lv[k] = 4'd0;
    end
  endtask

  task automatic cyc(input int d, input logic r, input logic e, input logic u, input logic l,
                     input logic [3:0] v, input logic [3:0] ec, input logic et, input string nm);
    idle_all();
    rst[d] = r; en[d] = e; up[d] = u; ld[d] = l; lv[d] = v;
    @(posedge clk);
    #1;
    sb.push_back(mk(d, ec, et, nm));
  endtask

  logic [3:0] t1c [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
  logic [3:0] t3c [5]  = '{4'd8, 4'd9, 4'd9, 4'd9, 4'd9};
  logic       t3t [5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic       t5e [8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [3:0] t5c [8]  = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2};
  logic [3:0] t6c [9]  = '{4'd2, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4, 4'd4, 4'd4, 4'd5};

  initial begin
    idle_all();
    #1;
    for (int k = 0; k < 3; k++) rst[k] = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) sb.push_back(mk(k, 4'd0, 1'b0, "reset"));

    for (int i = 0; i < 12; i++) cyc(0, 0, 1, 1, 0, 0, t1c[i], (i == 9), "t1_up_wrap");

    cyc(0, 1, 0, 0, 0, 0, 4'd0, 0, "t2_rst");
    cyc(0, 0, 1, 0, 0, 0, 4'd9, 1, "t2_down_wrap");
    cyc(0, 0, 1, 0, 0, 0, 4'd8, 0, "t2_down");
    cyc(0, 0, 1, 0, 0, 0, 4'd7, 0, "t2_down");

    cyc(0, 0, 0, 0, 1, 4'd12, 4'd9, 0, "t4_load_clamp");
    cyc(0, 0, 1, 1, 1, 4'd3, 4'd3, 0, "t4_load_prio");

    cyc(1, 0, 0, 0, 1, 4'd7, 4'd7, 0, "t3_load7");
    for (int i = 0; i < 5; i++) cyc(1, 0, 1, 1, 0, 0, t3c[i], t3t[i], "t3_sat_up");
    cyc(1, 0, 0, 0, 1, 4'd1, 4'd1, 0, "t3_load1");
    cyc(1, 0, 1, 0, 0, 0, 4'd0, 0, "t3_sat_down");
    cyc(1, 0, 1, 0, 0, 0, 4'd0, 1, "t3_sat_down_blocked");

    cyc(2, 1, 0, 0, 0, 0, 4'd0, 0, "t5_rst");
    for (int i = 0; i < 8; i++) cyc(2, 0, t5e[i], 1, 0, 0, t5c[i], 0, "t5_presc");

    for (int i = 0; i < 9; i++) cyc(2, 0, 1, 1, 0, 0, t6c[i], 0, "t6_to5");
    cyc(2, 0, 1, 1, 0, 0, 4'd5, 0, "t6_mid_presc");
    cyc(2, 1, 1, 1, 0, 0, 4'd0, 0, "t6_rst");
    cyc(2, 0, 1, 1, 0, 0, 4'd0, 0, "t6_presc_restart");
    cyc(2, 0, 1, 1, 0, 0, 4'd0, 0, "t6_presc_restart");
    cyc(2, 0, 1, 1, 0, 0, 4'd1, 0, "t6_full_period");

    idle_all();
    for (int w = 0; w < 4 && sb.size() > 0; w++) @(posedge clk);
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
